// File: rtl/rsa_seq_pkg.sv
// Shared types and defaults for the RSA job sequencer and its watchdog.
package rsa_seq_pkg;

    localparam int DEFAULT_WIDTH = 128;

    typedef logic [31:0] wdog_count_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INV_RST  = 3'd1,
        INV_WAIT = 3'd2,
        EXP_RST  = 3'd3,
        EXP_WAIT = 3'd4,
        DONE     = 3'd5
    } seq_state_t;

endpackage

// File: rtl/rsa_seq_watchdog.sv
// Saturating cycle counter shared by both finish-wait phases of the sequencer.
module rsa_seq_watchdog
    import rsa_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  wdog_count_t limit,
    output logic        expired
);

    wdog_count_t count;
    logic [32:0] count_inc;

    assign count_inc = {1'b0, count} + 33'd1;

    // Expiry is judged on the post-increment value so the limit equals the number of sampled cycles.
    assign expired = enable && (limit != '0) && (count_inc == {1'b0, limit});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count_inc[31:0];
        end
    end

endmodule

// File: rtl/rsa_job_sequencer.sv
// Valid/ready job front end for one RSA control core: sequences the inverter and
// mod-exp start pulses, waits for each finish and returns the result message.
module rsa_job_sequencer
    import rsa_seq_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_p,
    input  logic [WIDTH-1:0]     req_q,
    input  logic                 req_mode,
    input  logic [2*WIDTH-1:0]   req_msg,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_msg,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic [WIDTH-1:0]     core_p,
    output logic [WIDTH-1:0]     core_q,
    output logic                 core_encrypt_decrypt,
    output logic [2*WIDTH-1:0]   core_msg_in,
    output logic                 core_reset_inverter,
    output logic                 core_reset_mod_exp,
    input  logic                 core_inverter_finish,
    input  logic                 core_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   core_msg_out
);

    localparam wdog_count_t TIMEOUT_LIMIT = wdog_count_t'(TIMEOUT_CYCLES);

    seq_state_t         state;
    seq_state_t         state_next;
    logic               blank;
    logic               accept;
    logic               inv_sample;
    logic               exp_sample;
    logic               wd_clear;
    logic               wd_enable;
    logic               wd_expired;
    logic [2*WIDTH-1:0] rsp_msg_next;
    logic               rsp_timeout_next;

    assign accept     = (state == IDLE) && req_valid && req_ready;
    assign inv_sample = (state == INV_WAIT) && !blank;
    assign exp_sample = (state == EXP_WAIT) && !blank;
    assign wd_clear   = (state == INV_RST) || (state == EXP_RST);
    assign wd_enable  = (inv_sample && !core_inverter_finish) ||
                        (exp_sample && !core_mod_exp_finish);

    rsa_seq_watchdog u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (TIMEOUT_LIMIT),
        .expired (wd_expired)
    );

    // The cycle right after a start pulse is blanked so a finish left over from the previous run is ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            blank <= 1'b0;
        end else begin
            state <= state_next;
            blank <= wd_clear;
        end
    end

    always_comb begin
        state_next       = state;
        rsp_msg_next     = rsp_msg;
        rsp_timeout_next = rsp_timeout;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = INV_RST;
                end
            end
            INV_RST: begin
                state_next = INV_WAIT;
            end
            INV_WAIT: begin
                if (inv_sample) begin
                    if (core_inverter_finish) begin
                        state_next = EXP_RST;
                    end else if (wd_expired) begin
                        state_next       = DONE;
                        rsp_msg_next     = '0;
                        rsp_timeout_next = 1'b1;
                    end
                end
            end
            EXP_RST: begin
                state_next = EXP_WAIT;
            end
            EXP_WAIT: begin
                if (exp_sample) begin
                    if (core_mod_exp_finish) begin
                        state_next       = DONE;
                        rsp_msg_next     = core_msg_out;
                        rsp_timeout_next = 1'b0;
                    end else if (wd_expired) begin
                        state_next       = DONE;
                        rsp_msg_next     = '0;
                        rsp_timeout_next = 1'b1;
                    end
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of the next state, so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_ready            <= 1'b0;
            busy                 <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_msg              <= '0;
            rsp_timeout          <= 1'b0;
            core_reset_inverter  <= 1'b0;
            core_reset_mod_exp   <= 1'b0;
            core_p               <= '0;
            core_q               <= '0;
            core_encrypt_decrypt <= 1'b0;
            core_msg_in          <= '0;
        end else begin
            req_ready           <= (state_next == IDLE);
            busy                <= (state_next != IDLE);
            rsp_valid           <= (state_next == DONE);
            rsp_msg             <= rsp_msg_next;
            rsp_timeout         <= rsp_timeout_next;
            core_reset_inverter <= (state_next == INV_RST);
            core_reset_mod_exp  <= (state_next == EXP_RST);
            if (accept) begin
                core_p               <= req_p;
                core_q               <= req_q;
                core_encrypt_decrypt <= req_mode;
                core_msg_in          <= req_msg;
            end
        end
    end

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Scoreboard bench for rsa_job_sequencer driving a behavioural add/subtract stand-in core.
module tb_rsa_job_sequencer;

    localparam int WIDTH   = 128;
    localparam int MW      = 2 * WIDTH;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_p;
    logic [WIDTH-1:0] req_q;
    logic             req_mode;
    logic [MW-1:0]    req_msg;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [MW-1:0]    rsp_msg;
    logic             rsp_timeout;
    logic             busy;
    logic [WIDTH-1:0] core_p;
    logic [WIDTH-1:0] core_q;
    logic             core_encrypt_decrypt;
    logic [MW-1:0]    core_msg_in;
    logic             core_reset_inverter;
    logic             core_reset_mod_exp;
    logic             core_inverter_finish;
    logic             core_mod_exp_finish;
    logic [MW-1:0]    core_msg_out;
    logic             inv_fin = 1'b0;
    logic             exp_fin = 1'b0;

    localparam logic [WIDTH-1:0] P1 = 128'd113680897410347;
    localparam logic [WIDTH-1:0] Q1 = 128'd7999808077935876437321;
    localparam logic [MW-1:0]    M1 = 256'h28_0000_0000;
    localparam logic [WIDTH-1:0] P2 = 128'd8475698667747010771;
    localparam logic [WIDTH-1:0] Q2 = 128'd11297384090418420749;
    localparam logic [MW-1:0]    M2 = 256'h1b5e2b4d0e3f7795ebe2590000;
    localparam logic [WIDTH-1:0] P3 = 128'h1234_5678_9abc_def0;
    localparam logic [WIDTH-1:0] Q3 = 128'hfedc_ba98_7654_3210_0f0f;
    localparam logic [MW-1:0]    M3 = 256'hdead_beef_cafe_f00d_0123;
    localparam logic [WIDTH-1:0] P4 = 128'h55aa_0000_1111;
    localparam logic [WIDTH-1:0] Q4 = 128'h0bad_f00d;
    localparam logic [MW-1:0]    M4 = 256'h7777_0000_3333;

    always #5 clk = ~clk;

    rsa_job_sequencer #(
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_p                (req_p),
        .req_q                (req_q),
        .req_mode             (req_mode),
        .req_msg              (req_msg),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_msg              (rsp_msg),
        .rsp_timeout          (rsp_timeout),
        .busy                 (busy),
        .core_p               (core_p),
        .core_q               (core_q),
        .core_encrypt_decrypt (core_encrypt_decrypt),
        .core_msg_in          (core_msg_in),
        .core_reset_inverter  (core_reset_inverter),
        .core_reset_mod_exp   (core_reset_mod_exp),
        .core_inverter_finish (core_inverter_finish),
        .core_mod_exp_finish  (core_mod_exp_finish),
        .core_msg_out         (core_msg_out)
    );

    // Stand-in core: encrypt adds {p,q}, decrypt subtracts it, so a round trip restores the message.
    assign core_inverter_finish = inv_fin;
    assign core_mod_exp_finish  = exp_fin;
    assign core_msg_out = core_encrypt_decrypt ? (core_msg_in - {core_p, core_q})
                                               : (core_msg_in + {core_p, core_q});

    typedef struct {
        logic [MW-1:0] msg;
        logic          timeout;
    } rsp_t;

    rsp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    logic [MW-1:0] last_rsp = '0;

    task automatic checkOutput(input string name, input logic [MW-1:0] actual, input logic [MW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Offers a job and returns one tick into the cycle after the accepting edge (cycle 1).
    task automatic applyStimulus(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q, input logic mode,
                                 input logic [MW-1:0] msg, input bit expect_rsp,
                                 input logic [MW-1:0] exp_msg, input logic exp_to);
        bit   taken = 1'b0;
        rsp_t r;
        req_p     = p;
        req_q     = q;
        req_mode  = mode;
        req_msg   = msg;
        req_valid = 1'b1;
        if (expect_rsp) begin
            r.msg     = exp_msg;
            r.timeout = exp_to;
            sb.push_back(r);
        end
        for (int i = 0; i < 100 && !taken; i++) begin
            @(negedge clk);
            if (req_ready) taken = 1'b1;
            nextCycle();
        end
        req_valid = 1'b0;
        if (!taken) checkOutput("accept_bound", 0, 1);
    endtask

    task automatic waitDrain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1'b1;
            nextCycle();
        end
        checkOutput(name, ok, 1);
    endtask

    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && sb.size() == 0) begin
                checkOutput("unexpected_rsp", rsp_valid, 0);
            end else if (rsp_valid && rsp_ready) begin
                e = sb.pop_front();
                checkOutput("rsp_msg", rsp_msg, e.msg);
                checkOutput("rsp_timeout", rsp_timeout, e.timeout);
                last_rsp = rsp_msg;
            end
        end
    end

    initial begin : global_bound
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global time bound expired");
    end

    initial begin : stimulus
        int            errs;
        logic [MW-1:0] enc;
        rsp_t          r;
        req_valid = 1'b0;
        req_p     = '0;
        req_q     = '0;
        req_mode  = 1'b0;
        req_msg   = '0;
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", {req_ready, rsp_valid, rsp_timeout, busy, core_reset_inverter,
                                   core_reset_mod_exp, core_encrypt_decrypt}, 0);
        checkOutput("reset_data", rsp_msg | core_msg_in | {core_p, core_q}, 0);
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("ready_after_reset", {req_ready, busy}, 2'b10);
        nextCycle();

        $display("[TB] minimum latency");
        inv_fin   = 1'b1;
        exp_fin   = 1'b1;
        rsp_ready = 1'b1;
        applyStimulus(P1, Q1, 1'b0, M1, 1'b1, M1 + {P1, Q1}, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput($sformatf("latency_c%0d", k), {core_reset_inverter, core_reset_mod_exp, rsp_valid},
                        {k == 1, k == 4, k == 7});
            nextCycle();
        end
        waitDrain("latency_drain");

        $display("[TB] round trip");
        applyStimulus(P2, Q2, 1'b0, M2, 1'b1, M2 + {P2, Q2}, 1'b0);
        waitDrain("rt_encrypt");
        enc = last_rsp;
        applyStimulus(P2, Q2, 1'b1, enc, 1'b1, M2, 1'b0);
        waitDrain("rt_decrypt");

        $display("[TB] watchdog timeout");
        inv_fin = 1'b0;
        applyStimulus(P1, Q1, 1'b0, M1, 1'b1, '0, 1'b1);
        errs = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (rsp_valid || core_reset_mod_exp) errs++;
            nextCycle();
        end
        checkOutput("timeout_early", errs, 0);
        @(negedge clk);
        checkOutput("timeout_c19", {rsp_valid, rsp_timeout, core_reset_mod_exp}, 3'b110);
        nextCycle();
        waitDrain("timeout_drain");

        $display("[TB] backpressure");
        inv_fin   = 1'b1;
        rsp_ready = 1'b0;
        applyStimulus(P3, Q3, 1'b1, M3, 1'b1, M3 - {P3, Q3}, 1'b0);
        repeat (6) nextCycle();
        r.msg     = M4 + {P4, Q4};
        r.timeout = 1'b0;
        sb.push_back(r);
        req_p     = P4;
        req_q     = Q4;
        req_mode  = 1'b0;
        req_msg   = M4;
        req_valid = 1'b1;
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_msg !== (M3 - {P3, Q3}) || rsp_timeout || req_ready || core_p !== P3) errs++;
            nextCycle();
        end
        checkOutput("bp_hold", errs, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_c0", {req_ready, core_reset_inverter}, 2'b00);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_release_c1", {req_ready, core_reset_inverter, rsp_valid}, 3'b100);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_release_c2", {req_ready, core_reset_inverter, core_p == P4}, 3'b011);
        req_valid = 1'b0;
        nextCycle();
        waitDrain("bp_drain");

        $display("[TB] stale finish and operand stability");
        inv_fin = 1'b1;
        exp_fin = 1'b1;
        nextCycle();
        inv_fin = 1'b0;
        exp_fin = 1'b0;
        @(negedge clk);
        checkOutput("stale_idle", {busy, req_ready}, 2'b01);
        nextCycle();
        applyStimulus(P1, Q1, 1'b0, M2, 1'b1, M2 + {P1, Q1}, 1'b0);
        nextCycle();
        inv_fin = 1'b1;
        nextCycle();
        inv_fin = 1'b0;
        req_p   = P3;
        errs = 0;
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            if (core_reset_mod_exp || core_p !== P1) errs++;
            nextCycle();
        end
        inv_fin = 1'b1;
        @(negedge clk);
        if (core_reset_mod_exp || core_p !== P1) errs++;
        checkOutput("stale_blank_inv", errs, 0);
        nextCycle();
        inv_fin = 1'b0;
        @(negedge clk);
        checkOutput("stale_exp_rst", {core_reset_mod_exp, core_p == P1}, 2'b11);
        nextCycle();
        exp_fin = 1'b1;
        nextCycle();
        exp_fin = 1'b0;
        errs = 0;
        @(negedge clk);
        if (rsp_valid) errs++;
        nextCycle();
        exp_fin = 1'b1;
        @(negedge clk);
        if (rsp_valid) errs++;
        checkOutput("stale_blank_exp", errs, 0);
        nextCycle();
        waitDrain("stale_drain");

        $display("[TB] mid-job reset");
        inv_fin = 1'b1;
        exp_fin = 1'b0;
        applyStimulus(P2, Q2, 1'b1, M3, 1'b0, '0, 1'b0);
        repeat (5) nextCycle();
        @(negedge clk);
        checkOutput("mid_exp_wait", {busy, core_reset_mod_exp, rsp_valid}, 3'b100);
        nextCycle();
        reset_n = 1'b0;
        nextCycle();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_ctrl", {req_ready, rsp_valid, rsp_timeout, busy, core_reset_inverter,
                                       core_reset_mod_exp, core_encrypt_decrypt}, 0);
        checkOutput("mid_reset_data", rsp_msg | core_msg_in | {core_p, core_q}, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("mid_ready", {req_ready, rsp_valid, busy}, 3'b100);
        nextCycle();
        exp_fin = 1'b1;
        applyStimulus(P1, Q2, 1'b0, M3, 1'b1, M3 + {P1, Q2}, 1'b0);
        waitDrain("mid_followup");

        checkOutput("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_job_sequencer.md
Name: rsa_job_sequencer

Overview:
- Synthesizable initiator for one RSA `control` core. Replaces the hand-sequenced reset/finish handshake with a valid/ready job interface.
- Accepts a job (p, q, mode, message) and drives the core's operands. Pulses reset_inverter, waits for inverter_finish, pulses reset_mod_exp, waits for mod_exp_finish, then returns msg_out on a response handshake.
- Two instances chained (encrypt then decrypt) form the hardware round-trip path.

Parameters:
- WIDTH, 128, prime width; message and result are 2*WIDTH.
- TIMEOUT_CYCLES, 1048576, maximum sampling cycles in each wait state; 0 disables the watchdog.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  job offered.
- req_ready  out  1  sequencer idle, can accept.
- req_p  in  WIDTH  prime p.
- req_q  in  WIDTH  prime q.
- req_mode  in  1  0=encrypt, 1=decrypt (maps to encrypt_decrypt).
- req_msg  in  2*WIDTH  input message.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_msg  out  2*WIDTH  result message.
- rsp_timeout  out  1  job aborted by watchdog (qualifies rsp_valid).
- busy  out  1  state != IDLE.
- core_p, core_q  out  WIDTH  operands to core.
- core_encrypt_decrypt  out  1  mode to core.
- core_msg_in  out  2*WIDTH  message to core.
- core_reset_inverter  out  1  one-cycle start pulse, inverter phase.
- core_reset_mod_exp  out  1  one-cycle start pulse, mod-exp phase.
- core_inverter_finish  in  1  core inverter done.
- core_mod_exp_finish  in  1  core mod-exp done.
- core_msg_out  in  2*WIDTH  core result.

Behaviour:
- All outputs are registered.
- Reset (reset_n=0 at a rising edge), regardless of state:
  - state=IDLE;
  - core_* operands, rsp_msg, rsp_timeout, rsp_valid, both core resets, busy all 0;
  - req_ready=0 during reset, 1 from the first cycle after release.
  - An in-flight job is dropped silently; no response is produced.
- States: IDLE, INV_RST, INV_WAIT, EXP_RST, EXP_WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_* into core_* and go to INV_RST.
  - req_ready drops the next cycle.
- INV_RST:
  - core_reset_inverter=1 for exactly this one cycle.
  - Clear the watchdog; go to INV_WAIT.
- INV_WAIT:
  - The first cycle is a blanking cycle; finish is not sampled (guards against a stale finish).
  - From the second cycle, core_inverter_finish=1 takes the state to EXP_RST.
  - Each sampled cycle without finish increments the watchdog.
  - Watchdog==TIMEOUT_CYCLES (when nonzero) takes the state to DONE with rsp_timeout=1 and rsp_msg=0. EXP_RST is never entered.
- EXP_RST: core_reset_mod_exp=1 for exactly one cycle; clear the watchdog; go to EXP_WAIT.
- EXP_WAIT:
  - Same blanking and watchdog rules as INV_WAIT, using core_mod_exp_finish.
  - On finish, capture core_msg_out into rsp_msg, set rsp_timeout=0, go to DONE.
- DONE:
  - rsp_valid=1; rsp_msg and rsp_timeout are held stable.
  - When rsp_ready=1, go to IDLE; rsp_valid=0 the next cycle.
  - No same-cycle bypass to a new accept: minimum two cycles between responses.
- Operand stability: core_p, core_q, core_encrypt_decrypt and core_msg_in hold from accept until the rsp handshake completes. They change only on an accept.
- Timing:
  - Minimum latency: accept at cycle 0, rsp_valid at cycle 7, with both finishes already high.
  - Finish pulses in IDLE, *_RST, DONE or blanking cycles are ignored.
- Watchdog counter width is 32 bits and saturates. TIMEOUT_CYCLES=0 means wait forever.

Decomposition:
- Package rsa_seq_pkg holds:
  - the state enum (6 states, 3-bit encoding);
  - default WIDTH=128;
  - the 32-bit watchdog count type.
- One sub-module, rsa_seq_watchdog: clear, enable, limit, and expired output; used by both wait states.

Test Plan:
- Min latency: behavioural core holds both finish=1; accept p=113680897410347, q=7999808077935876437321, mode=0, msg=0x28_0000_0000. Required:
  - core_reset_inverter high only at cycle 1;
  - core_reset_mod_exp high only at cycle 4;
  - rsp_valid at cycle 7 with rsp_msg = model output.
- Round trip with real control core, WIDTH=128: instance A (mode 0) runs p=8475698667747010771, q=11297384090418420749, msg=0x1b5e2b4d0e3f7795ebe2590000. Instance B (mode 1) takes A's rsp_msg. Required: B rsp_msg equals the original msg and rsp_timeout=0 for both.
- Timeout: TIMEOUT_CYCLES=16, inverter_finish tied 0. Required:
  - rsp_valid with rsp_timeout=1 and rsp_msg=0 exactly 16 sampled cycles after blanking;
  - core_reset_mod_exp never asserted.
- Backpressure: rsp_ready=0 for 20 cycles in DONE. Required:
  - rsp_valid and rsp_msg stable;
  - req_ready=0 while a competing req_valid is held;
  - after rsp_ready=1, the new job is accepted no earlier than 2 cycles later.
- Stale finish and operand stability: finish pulses in IDLE and in the blanking cycle do not advance state; req_p changes during busy do not alter core_p.
- Mid-job reset: reset_n=0 for one cycle during EXP_WAIT. Required:
  - next cycle state IDLE and all outputs 0;
  - no rsp_valid;
  - a following job completes normally.
